// File: rtl/frame_writer.sv
// frame_writer: fills a ROWS x COLS frame buffer in raster order from a valid/ready stream,
// with a zero-latency combinational read port.
module frame_writer #(
  parameter int ROWS = 10,
  parameter int COLS = 20,
  parameter int DW   = 12,
  parameter int AW   = 10
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] rd_x,
  input  logic [AW-1:0] rd_y,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] wr_x,
  output logic [AW-1:0] wr_y,
  output logic          busy,
  output logic          done
);
  localparam int XW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int YW = COLS > 1 ? $clog2(COLS) : 1;
  localparam logic [AW-1:0] LAST_X = AW'(ROWS - 1);
  localparam logic [AW-1:0] LAST_Y = AW'(COLS - 1);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state, state_n;
  logic [AW-1:0] x_n, y_n;
  logic [DW-1:0] mem [ROWS][COLS];
  logic accept, last_col, last_row;
  assign busy     = state == FILL;
  assign in_ready = busy;
  assign done     = state == DONE;
  assign accept   = in_valid && busy;
  assign last_col = wr_y == LAST_Y;
  assign last_row = wr_x == LAST_X;
  always_comb begin
    state_n = state;
    x_n = wr_x;
    y_n = wr_y;
    case (state)
      IDLE: if (start) begin
        state_n = FILL;
        x_n = '0;
        y_n = '0;
      end
      FILL: if (accept) begin
        state_n = last_col && last_row ? DONE : FILL;
        x_n = last_col ? (last_row ? '0 : wr_x + 1'b1) : wr_x;
        y_n = last_col ? '0 : wr_y + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wr_x <= '0;
      wr_y <= '0;
    end else begin
      state <= state_n;
      wr_x <= x_n;
      wr_y <= y_n;
    end
  // Storage has no reset so frame contents survive an aborted fill
  always_ff @(posedge clk)
    if (accept) mem[wr_x[XW-1:0]][wr_y[YW-1:0]] <= in_data;
  assign rd_data = ({1'b0, rd_x} < (AW+1)'(ROWS) && {1'b0, rd_y} < (AW+1)'(COLS))
                   ? mem[rd_x[XW-1:0]][rd_y[YW-1:0]] : '0;
endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: randomized self-checking bench with a raster-order array model of the frame.
`timescale 1ns/1ps
module tb_frame_writer;
  localparam int ROWS = 10, COLS = 20, DW = 12, AW = 10, N = ROWS * COLS;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_ready, busy, done;
  logic [DW-1:0] in_data = '0, rd_data;
  logic [AW-1:0] rd_x = '0, rd_y = '0, wr_x, wr_y;
  int checks = 0, failures = 0, k = 0;
  logic [DW-1:0] mdl [ROWS][COLS];

  frame_writer #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .wr_x(wr_x),
    .wr_y(wr_y), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame;
    start = 1;
    step();
    start = 0;
    k = 0;
  endtask

  // One accepted beat: the k-th beat of a frame lands at (k / COLS, k % COLS)
  task automatic beat(input logic [DW-1:0] d);
    in_valid = 1;
    in_data = d;
    step();
    mdl[k / COLS][k % COLS] = d;
    k++;
  endtask

  task automatic test_reset;
    rst_n = 0;
    step();
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0d want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %0d want 0", in_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0d want 0", done); end
    checks++; if (wr_x !== '0 || wr_y !== '0) begin failures++; $display("FAIL reset_wr: got (%0d,%0d) want (0,0)", wr_x, wr_y); end
    #2 rst_n = 1;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_start: busy got %0d want 0", busy); end
  endtask

  task automatic test_full_fill;
    start_frame();
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL fill_enter: busy=%0d in_ready=%0d want 1,1", busy, in_ready); end
    checks++; if (wr_x !== '0 || wr_y !== '0) begin failures++; $display("FAIL fill_origin: got (%0d,%0d) want (0,0)", wr_x, wr_y); end
    for (int i = 0; i < N; i++) begin
      beat(DW'((i / COLS) * COLS + i % COLS));
      if (k == 19) begin
        checks++; if (wr_x !== 0 || wr_y !== 19) begin failures++; $display("FAIL wrap_19: got (%0d,%0d) want (0,19)", wr_x, wr_y); end
      end
      if (k == 20) begin
        checks++; if (wr_x !== 1 || wr_y !== 0) begin failures++; $display("FAIL wrap_20: got (%0d,%0d) want (1,0)", wr_x, wr_y); end
      end
      if (k < N && done !== 1'b0) begin checks++; failures++; $display("FAIL early_done: beat %0d", k); end
    end
    in_valid = 0;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL done_pulse: done=%0d busy=%0d want 1,0", done, busy); end
    checks++; if (wr_x !== '0 || wr_y !== '0) begin failures++; $display("FAIL done_wr: got (%0d,%0d) want (0,0)", wr_x, wr_y); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL done_one_cycle: done=%0d busy=%0d want 0,0", done, busy); end
    rd_x = 3; rd_y = 7; #1;
    checks++; if (rd_data !== DW'(67)) begin failures++; $display("FAIL rd_3_7: got %0d want 67", rd_data); end
    rd_x = 9; rd_y = 19; #1;
    checks++; if (rd_data !== DW'(199)) begin failures++; $display("FAIL rd_9_19: got %0d want 199", rd_data); end
  endtask

  task automatic test_stall;
    int cyc = 0;
    start_frame();
    for (int i = 0; i < 20; i++) beat(DW'($urandom));
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      in_data = DW'($urandom);
      step();
      checks++; if (wr_x !== 1 || wr_y !== 0 || busy !== 1'b1) begin failures++; $display("FAIL stall_hold: got (%0d,%0d) busy=%0d want (1,0) busy=1", wr_x, wr_y, busy); end
    end
    rd_x = 1; rd_y = 0; #1;
    checks++; if (rd_data !== mdl[1][0]) begin failures++; $display("FAIL stall_no_write: got %0d want %0d", rd_data, mdl[1][0]); end
    while (k < N && cyc < 5000) begin
      cyc++;
      if ($urandom % 3 != 0) beat(DW'($urandom));
      else begin in_valid = 0; step(); end
      if (k < N) begin
        checks++; if (wr_x !== AW'(k / COLS) || wr_y !== AW'(k % COLS) || busy !== 1'b1) begin failures++; $display("FAIL rand_pos: got (%0d,%0d) want (%0d,%0d)", wr_x, wr_y, k / COLS, k % COLS); end
      end
    end
    in_valid = 0;
    checks++; if (k != N || done !== 1'b1) begin failures++; $display("FAIL rand_done: beats=%0d done=%0d want %0d,1", k, done, N); end
    step();
    for (int x = 0; x < ROWS; x++)
      for (int y = 0; y < COLS; y++) begin
        rd_x = AW'(x); rd_y = AW'(y); #1;
        checks++; if (rd_data !== mdl[x][y]) begin failures++; $display("FAIL mem_%0d_%0d: got %0d want %0d", x, y, rd_data, mdl[x][y]); end
      end
  endtask

  task automatic test_ignored;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = DW'($urandom);
      step();
      checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || wr_x !== '0 || wr_y !== '0) begin failures++; $display("FAIL idle_valid: busy=%0d (%0d,%0d) want 0 (0,0)", busy, wr_x, wr_y); end
    end
    in_valid = 0;
    rd_x = 0; rd_y = 0; #1;
    checks++; if (rd_data !== mdl[0][0]) begin failures++; $display("FAIL idle_mem: got %0d want %0d", rd_data, mdl[0][0]); end
    start_frame();
    for (int i = 0; i < 5; i++) beat(DW'($urandom));
    in_valid = 0;
    start = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (wr_x !== 0 || wr_y !== 5 || busy !== 1'b1) begin failures++; $display("FAIL fill_start: got (%0d,%0d) busy=%0d want (0,5) 1", wr_x, wr_y, busy); end
    end
    start = 0;
    while (k < N) beat(DW'($urandom));
    in_valid = 0;
    start = 1;
    step();
    start = 0;
    step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL done_start: busy=%0d done=%0d want 0,0", busy, done); end
  endtask

  task automatic test_read_boundaries;
    logic [DW-1:0] d;
    rd_x = 10; rd_y = 0; #1;
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL rd_x_oob: got %0d want 0", rd_data); end
    rd_x = 0; rd_y = 20; #1;
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL rd_y_oob: got %0d want 0", rd_data); end
    rd_x = 1023; rd_y = 1023; #1;
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL rd_max_oob: got %0d want 0", rd_data); end
    start_frame();
    for (int i = 0; i < 3; i++) beat(DW'($urandom));
    rd_x = 0; rd_y = 3;
    d = ~mdl[0][3];
    in_valid = 1; in_data = d; #1;
    checks++; if (rd_data !== mdl[0][3]) begin failures++; $display("FAIL rd_old: got %0d want %0d", rd_data, mdl[0][3]); end
    step();
    mdl[0][3] = d;
    k++;
    checks++; if (rd_data !== d) begin failures++; $display("FAIL rd_new: got %0d want %0d", rd_data, d); end
    while (k < N) beat(DW'($urandom));
    in_valid = 0;
    step();
  endtask

  task automatic test_reset_mid_frame;
    logic [DW-1:0] d;
    start_frame();
    for (int i = 0; i < 50; i++) beat(DW'($urandom));
    #2 rst_n = 0;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL async_rst: busy=%0d in_ready=%0d done=%0d want 0", busy, in_ready, done); end
    checks++; if (wr_x !== '0 || wr_y !== '0) begin failures++; $display("FAIL async_rst_wr: got (%0d,%0d) want (0,0)", wr_x, wr_y); end
    in_valid = 0;
    rd_x = 2; rd_y = 5; #1;
    checks++; if (rd_data !== mdl[2][5]) begin failures++; $display("FAIL rst_retain: got %0d want %0d", rd_data, mdl[2][5]); end
    #1 rst_n = 1;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle: busy got %0d want 0", busy); end
    start_frame();
    checks++; if (wr_x !== '0 || wr_y !== '0) begin failures++; $display("FAIL restart_origin: got (%0d,%0d) want (0,0)", wr_x, wr_y); end
    d = ~mdl[0][0];
    beat(d);
    in_valid = 0;
    rd_x = 0; rd_y = 0; #1;
    checks++; if (rd_data !== d || wr_y !== 1) begin failures++; $display("FAIL restart_write: got %0d wr_y=%0d want %0d wr_y=1", rd_data, wr_y, d); end
  endtask

  initial begin
    test_reset();
    test_full_fill();
    test_stall();
    test_ignored();
    test_read_boundaries();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
